// File: rtl/vsm_out_port.sv
// vsm_out_port: parametrised output port of the VSM datapath.
// Captures IB on LoadOut and presents it on Out with a valid/ack handshake.
// The port is either a single holding register or a show-ahead FIFO.
// It reports full and sticky overflow status back to the controller.
module vsm_out_port #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 4,
    parameter int BUFFERED = 1
) (
    input  logic             MainClock,
    input  logic             invMainReset,
    input  logic [WIDTH-1:0] IB,
    input  logic             LoadOut,
    output logic [WIDTH-1:0] Out,
    output logic             OutValid,
    input  logic             OutAck,
    output logic             OutFull,
    output logic             OutOverflow,
    input  logic             ClearOvf
);

    if (BUFFERED == 0) begin : g_register

        logic [WIDTH-1:0] out_q, out_d;
        logic             valid_q, valid_d;
        logic             ovf_q, ovf_d;
        logic             pop;
        logic             ovf_event;

        assign pop = valid_q & OutAck;

        // Next-state logic: a load always wins; an unconsumed word being replaced is an overflow.
        always_comb begin
            out_d     = out_q;
            valid_d   = valid_q;
            ovf_event = 1'b0;
            if (LoadOut) begin
                out_d     = IB;
                valid_d   = 1'b1;
                ovf_event = valid_q & ~pop;
            end else if (pop) begin
                valid_d = 1'b0;
            end
            if (ovf_event) begin
                ovf_d = 1'b1;
            end else if (ClearOvf) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end
        end

        // State registers with asynchronous active-low reset.
        always_ff @(posedge MainClock or negedge invMainReset) begin
            if (!invMainReset) begin
                out_q   <= '0;
                valid_q <= 1'b0;
                ovf_q   <= 1'b0;
            end else begin
                out_q   <= out_d;
                valid_q <= valid_d;
                ovf_q   <= ovf_d;
            end
        end

        assign Out         = out_q;
        assign OutValid    = valid_q;
        assign OutFull     = valid_q;
        assign OutOverflow = ovf_q;

    end else begin : g_fifo

        localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam int CW = AW + 1;

        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [AW-1:0]    rd_next;
        logic [CW-1:0]    count_q, count_d;
        logic [WIDTH-1:0] out_q, out_d;
        logic             valid_q, valid_d;
        logic             full_q, full_d;
        logic             ovf_q, ovf_d;
        logic             pop;
        logic             at_full;
        logic             do_write;
        logic             ovf_event;

        assign pop = valid_q & OutAck;

        // Pointer, count and show-ahead output computation; Out always mirrors the oldest entry.
        always_comb begin
            at_full   = (count_q == CW'(DEPTH));
            do_write  = LoadOut & (~at_full | pop);
            ovf_event = LoadOut & at_full & ~pop;
            rd_next   = rd_ptr_q + AW'(1);
            wr_ptr_d  = do_write ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
            rd_ptr_d  = pop ? rd_next : rd_ptr_q;
            count_d   = count_q + CW'(do_write) - CW'(pop);
            out_d     = out_q;
            if (pop) begin
                if (count_q == CW'(1)) begin
                    if (do_write) begin
                        out_d = IB;
                    end
                end else begin
                    out_d = mem[rd_next];
                end
            end else if ((count_q == '0) && do_write) begin
                out_d = IB;
            end
            valid_d = (count_d != '0);
            full_d  = (count_d == CW'(DEPTH));
            if (ovf_event) begin
                ovf_d = 1'b1;
            end else if (ClearOvf) begin
                ovf_d = 1'b0;
            end else begin
                ovf_d = ovf_q;
            end
        end

        // Storage array, deliberately left out of reset.
        always_ff @(posedge MainClock) begin
            if (do_write) begin
                mem[wr_ptr_q] <= IB;
            end
        end

        // Control and output registers with asynchronous active-low reset.
        always_ff @(posedge MainClock or negedge invMainReset) begin
            if (!invMainReset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                out_q    <= '0;
                valid_q  <= 1'b0;
                full_q   <= 1'b0;
                ovf_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                out_q    <= out_d;
                valid_q  <= valid_d;
                full_q   <= full_d;
                ovf_q    <= ovf_d;
            end
        end

        assign Out         = out_q;
        assign OutValid    = valid_q;
        assign OutFull     = full_q;
        assign OutOverflow = ovf_q;

    end

endmodule

// File: tb/tb_vsm_out_port.sv
// Testbench for vsm_out_port: one FIFO instance and one register-mode instance,
// checked against queue-based reference models and directed expectations.
module tb_vsm_out_port;

    localparam int DEPTH = 4;

    logic       MainClock = 1'b0;
    logic       invMainReset;

    logic [3:0] ib_b, out_b;
    logic       load_b, ack_b, clr_b, valid_b, full_b, ovf_b;
    logic [3:0] ib_r, out_r;
    logic       load_r, ack_r, clr_r, valid_r, full_r, ovf_r;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [3:0] q_b[$];
    logic [3:0] m_out_b;
    logic       m_ovf_b;
    logic [3:0] m_out_r;
    logic       m_valid_r;
    logic       m_ovf_r;

    always #5 MainClock = ~MainClock;

    vsm_out_port #(.WIDTH(4), .DEPTH(DEPTH), .BUFFERED(1)) dut_fifo (
        .MainClock(MainClock), .invMainReset(invMainReset), .IB(ib_b), .LoadOut(load_b),
        .Out(out_b), .OutValid(valid_b), .OutAck(ack_b), .OutFull(full_b),
        .OutOverflow(ovf_b), .ClearOvf(clr_b)
    );

    vsm_out_port #(.WIDTH(4), .DEPTH(DEPTH), .BUFFERED(0)) dut_reg (
        .MainClock(MainClock), .invMainReset(invMainReset), .IB(ib_r), .LoadOut(load_r),
        .Out(out_r), .OutValid(valid_r), .OutAck(ack_r), .OutFull(full_r),
        .OutOverflow(ovf_r), .ClearOvf(clr_r)
    );

    function automatic void model_reset();
        q_b.delete();
        m_out_b   = 4'h0;
        m_ovf_b   = 1'b0;
        m_out_r   = 4'h0;
        m_valid_r = 1'b0;
        m_ovf_r   = 1'b0;
    endfunction

    // Advance both models by one clock edge using the currently driven inputs.
    function automatic void model_step();
        bit ev_b;
        bit ev_r;
        bit pop_r;
        ev_b = 1'b0;
        if (q_b.size() > 0 && ack_b) void'(q_b.pop_front());
        if (load_b) begin
            if (q_b.size() < DEPTH) q_b.push_back(ib_b);
            else ev_b = 1'b1;
        end
        if (q_b.size() > 0) m_out_b = q_b[0];
        if (ev_b) m_ovf_b = 1'b1;
        else if (clr_b) m_ovf_b = 1'b0;

        ev_r  = 1'b0;
        pop_r = m_valid_r && ack_r;
        if (load_r) begin
            ev_r      = m_valid_r && !pop_r;
            m_out_r   = ib_r;
            m_valid_r = 1'b1;
        end else if (pop_r) begin
            m_valid_r = 1'b0;
        end
        if (ev_r) m_ovf_r = 1'b1;
        else if (clr_r) m_ovf_r = 1'b0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge MainClock);
        #1;
    endtask

    task automatic test_reset();
        load_b = 1'b1; ib_b = 4'hA;
        load_r = 1'b1; ib_r = 4'hC;
        tick();
        load_b = 1'b0; load_r = 1'b0;
        checks++;
        if ({out_b, valid_b} !== {4'hA, 1'b1}) begin
            failures++;
            $display("FAIL pre_reset_load got out=%h valid=%b exp out=a valid=1", out_b, valid_b);
        end
        #2 invMainReset = 1'b0;
        #1;
        checks++;
        if ({out_b, valid_b, full_b, ovf_b} !== 7'h0) begin
            failures++;
            $display("FAIL async_reset_fifo got out=%h v=%b f=%b o=%b exp all 0", out_b, valid_b, full_b, ovf_b);
        end
        checks++;
        if ({out_r, valid_r, full_r, ovf_r} !== 7'h0) begin
            failures++;
            $display("FAIL async_reset_reg got out=%h v=%b f=%b o=%b exp all 0", out_r, valid_r, full_r, ovf_r);
        end
        model_reset();
        #1 invMainReset = 1'b1;
    endtask

    task automatic test_basic();
        load_b = 1'b1; ib_b = 4'hA;
        tick();
        load_b = 1'b0;
        checks++;
        if ({out_b, valid_b} !== {4'hA, 1'b1}) begin
            failures++;
            $display("FAIL basic_load got out=%h valid=%b exp out=a valid=1", out_b, valid_b);
        end
        ack_b = 1'b1;
        tick();
        ack_b = 1'b0;
        checks++;
        if ({out_b, valid_b} !== {4'hA, 1'b0}) begin
            failures++;
            $display("FAIL basic_ack got out=%h valid=%b exp out=a valid=0", out_b, valid_b);
        end
    endtask

    task automatic test_fill_overflow();
        load_b = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ib_b = 4'(i);
            tick();
        end
        checks++;
        if ({out_b, full_b, ovf_b} !== {4'h1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL fill_full got out=%h full=%b ovf=%b exp out=1 full=1 ovf=0", out_b, full_b, ovf_b);
        end
        ib_b = 4'h5;
        tick();
        load_b = 1'b0;
        checks++;
        if ({out_b, full_b, ovf_b} !== {4'h1, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL fill_overflow got out=%h full=%b ovf=%b exp out=1 full=1 ovf=1", out_b, full_b, ovf_b);
        end
        ack_b = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({out_b, valid_b} !== {4'(i), 1'b1}) begin
                failures++;
                $display("FAIL drain_seq got out=%h valid=%b exp out=%h valid=1", out_b, valid_b, 4'(i));
            end
            tick();
        end
        ack_b = 1'b0;
        checks++;
        if ({out_b, valid_b, full_b, ovf_b} !== {4'h4, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL drain_empty got out=%h v=%b f=%b o=%b exp out=4 v=0 f=0 o=1", out_b, valid_b, full_b, ovf_b);
        end
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        checks++;
        if (ovf_b !== 1'b0) begin
            failures++;
            $display("FAIL clear_ovf got ovf=%b exp ovf=0", ovf_b);
        end
    endtask

    task automatic test_simultaneous_full();
        logic [3:0] expv[4];
        expv[0] = 4'h2; expv[1] = 4'h3; expv[2] = 4'h4; expv[3] = 4'h9;
        load_b = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            ib_b = 4'(i);
            tick();
        end
        ib_b  = 4'h9;
        ack_b = 1'b1;
        tick();
        load_b = 1'b0;
        checks++;
        if ({out_b, full_b, ovf_b} !== {4'h2, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL full_push_pop got out=%h full=%b ovf=%b exp out=2 full=1 ovf=0", out_b, full_b, ovf_b);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({out_b, valid_b} !== {expv[i], 1'b1}) begin
                failures++;
                $display("FAIL full_drain got out=%h valid=%b exp out=%h valid=1", out_b, valid_b, expv[i]);
            end
            tick();
        end
        ack_b = 1'b0;
        checks++;
        if ({valid_b, full_b} !== 2'b00) begin
            failures++;
            $display("FAIL full_drain_empty got valid=%b full=%b exp 0 0", valid_b, full_b);
        end
    endtask

    task automatic test_pointer_wrap();
        logic [3:0] w;
        load_b = 1'b1;
        ack_b  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w    = 4'($urandom_range(15));
            ib_b = w;
            tick();
            checks++;
            if ({out_b, valid_b, full_b, ovf_b} !== {w, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL wrap_stream idx=%0d got out=%h v=%b f=%b o=%b exp out=%h v=1 f=0 o=0",
                         i, out_b, valid_b, full_b, ovf_b, w);
            end
        end
        load_b = 1'b0;
        tick();
        ack_b = 1'b0;
        checks++;
        if (valid_b !== 1'b0) begin
            failures++;
            $display("FAIL wrap_empty got valid=%b exp valid=0", valid_b);
        end
    endtask

    task automatic test_register_mode();
        load_r = 1'b1; ib_r = 4'h3;
        tick();
        ib_r = 4'h5;
        tick();
        load_r = 1'b0;
        checks++;
        if ({out_r, valid_r, ovf_r} !== {4'h5, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reg_overwrite got out=%h valid=%b ovf=%b exp out=5 valid=1 ovf=1", out_r, valid_r, ovf_r);
        end
        clr_r = 1'b1;
        tick();
        clr_r = 1'b0;
        checks++;
        if ({out_r, valid_r, ovf_r} !== {4'h5, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reg_clear got out=%h valid=%b ovf=%b exp out=5 valid=1 ovf=0", out_r, valid_r, ovf_r);
        end
        load_r = 1'b1; ib_r = 4'h6; ack_r = 1'b1;
        tick();
        load_r = 1'b0; ack_r = 1'b0;
        checks++;
        if ({out_r, valid_r, full_r, ovf_r} !== {4'h6, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reg_load_ack got out=%h v=%b f=%b o=%b exp out=6 v=1 f=1 o=0", out_r, valid_r, full_r, ovf_r);
        end
        load_r = 1'b1; ib_r = 4'h8; clr_r = 1'b1;
        tick();
        load_r = 1'b0; clr_r = 1'b0;
        checks++;
        if ({out_r, ovf_r} !== {4'h8, 1'b1}) begin
            failures++;
            $display("FAIL reg_set_wins got out=%h ovf=%b exp out=8 ovf=1", out_r, ovf_r);
        end
        ack_r = 1'b1; clr_r = 1'b1;
        tick();
        ack_r = 1'b0; clr_r = 1'b0;
        checks++;
        if ({valid_r, full_r, ovf_r} !== 3'b000) begin
            failures++;
            $display("FAIL reg_pop got v=%b f=%b o=%b exp 0 0 0", valid_r, full_r, ovf_r);
        end
    endtask

    task automatic test_reset_midstream();
        load_b = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ib_b = 4'(i + 10);
            tick();
        end
        load_b = 1'b0;
        #2 invMainReset = 1'b0;
        #1;
        checks++;
        if ({out_b, valid_b, full_b} !== 6'h0) begin
            failures++;
            $display("FAIL midstream_reset got out=%h valid=%b full=%b exp 0 0 0", out_b, valid_b, full_b);
        end
        model_reset();
        #1 invMainReset = 1'b1;
        load_b = 1'b1; ib_b = 4'h7;
        tick();
        load_b = 1'b0;
        checks++;
        if ({out_b, valid_b} !== {4'h7, 1'b1}) begin
            failures++;
            $display("FAIL midstream_reload got out=%h valid=%b exp out=7 valid=1", out_b, valid_b);
        end
    endtask

    task automatic test_random();
        logic [6:0] exp_b;
        logic [6:0] exp_r;
        for (int i = 0; i < 400; i++) begin
            load_b = ($urandom_range(99) < 55);
            ack_b  = ($urandom_range(99) < 45);
            clr_b  = ($urandom_range(99) < 10);
            ib_b   = 4'($urandom_range(15));
            load_r = ($urandom_range(99) < 50);
            ack_r  = ($urandom_range(99) < 50);
            clr_r  = ($urandom_range(99) < 10);
            ib_r   = 4'($urandom_range(15));
            tick();
            exp_b = {m_out_b, q_b.size() != 0, q_b.size() == DEPTH, m_ovf_b};
            exp_r = {m_out_r, m_valid_r, m_valid_r, m_ovf_r};
            checks++;
            if ({out_b, valid_b, full_b, ovf_b} !== exp_b) begin
                failures++;
                $display("FAIL random_fifo cyc=%0d got {out,v,f,o}=%h exp=%h", i, {out_b, valid_b, full_b, ovf_b}, exp_b);
            end
            checks++;
            if ({out_r, valid_r, full_r, ovf_r} !== exp_r) begin
                failures++;
                $display("FAIL random_reg cyc=%0d got {out,v,f,o}=%h exp=%h", i, {out_r, valid_r, full_r, ovf_r}, exp_r);
            end
        end
        load_b = 1'b0; ack_b = 1'b0; clr_b = 1'b0;
        load_r = 1'b0; ack_r = 1'b0; clr_r = 1'b0;
    endtask

    initial begin
        invMainReset = 1'b0;
        ib_b = 4'h0; load_b = 1'b0; ack_b = 1'b0; clr_b = 1'b0;
        ib_r = 4'h0; load_r = 1'b0; ack_r = 1'b0; clr_r = 1'b0;
        model_reset();
        repeat (2) @(posedge MainClock);
        #4 invMainReset = 1'b1;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_simultaneous_full();
        test_pointer_wrap();
        test_register_mode();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
